// File: rtl/ddr_responder.sv
// rtl/ddr_responder.sv - DDR-side memory responder with fixed latency; DDR_RESP_RANDOM_STALL_EN adds LFSR-driven extra latency
module ddr_responder #(
  parameter int LINE_AW = 10,
  parameter int RD_LAT  = 4,
  parameter int WR_LAT  = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ddr_chip_enable,
  input  logic [63:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [511:0] ddr_write_data,
  output logic [511:0] ddr_read_data,
  output logic         ddr_operation_done,
  output logic         ddr_ready
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 8) + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  generate
    if (RD_LAT < 1 || WR_LAT < 1) begin : g_bad_latency
      $error("ddr_responder: RD_LAT and WR_LAT must both be at least 1");
    end
  endgenerate

  state_t             state_q, state_d;
  cnt_t               cnt_q, cnt_d, load_val;
  logic               accept, finish;

  logic [LINE_AW-1:0] line_q;
  logic [2:0]         word_q;
  logic               we_q, burst_q;
  logic [511:0]       wdata_q;

  logic [LINE_AW-1:0] acc_line;
  logic [2:0]         acc_word;
  logic               acc_we, acc_burst;
  logic [511:0]       acc_wdata;

  logic [511:0]       mem [0:(1<<LINE_AW)-1];

  logic               unused_idx;
  assign unused_idx = ^ddr_index[63:LINE_AW+3];

`ifdef DDR_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  // Galois LFSR x^16+x^14+x^13+x^11+1, free-running, supplies 0-7 extra latency cycles
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // Counter preload for a newly accepted request: latency minus one, plus any random stall
  always_comb begin
    load_val = ddr_write_enable ? cnt_t'(WR_LAT - 1) : cnt_t'(RD_LAT - 1);
`ifdef DDR_RESP_RANDOM_STALL_EN
    load_val = load_val + cnt_t'(lfsr_q[2:0]);
`endif
  end

  // Next-state logic: accept in IDLE, count down in BUSY, single-cycle DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ddr_ready && ddr_chip_enable) begin
          accept  = 1'b1;
          cnt_d   = load_val;
          state_d = (load_val == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == cnt_t'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finish = (state_d == DONE);

  // A zero-latency preload jumps straight to DONE, so use live inputs on the accept cycle
  always_comb begin
    acc_line  = accept ? ddr_index[LINE_AW+2:3] : line_q;
    acc_word  = accept ? ddr_index[2:0]         : word_q;
    acc_we    = accept ? ddr_write_enable       : we_q;
    acc_burst = accept ? ddr_burst_mode         : burst_q;
    acc_wdata = accept ? ddr_write_data         : wdata_q;
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      ddr_ready          <= 1'b0;
      ddr_operation_done <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      ddr_ready          <= (state_d == IDLE);
      ddr_operation_done <= finish;
    end
  end

  // Capture request fields at acceptance; inputs are ignored while busy
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      line_q  <= ddr_index[LINE_AW+2:3];
      word_q  <= ddr_index[2:0];
      we_q    <= ddr_write_enable;
      burst_q <= ddr_burst_mode;
      wdata_q <= ddr_write_data;
    end
  end

  // Backing store write on entry to DONE; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (!reset && finish && acc_we) begin
      if (acc_burst) mem[acc_line] <= acc_wdata;
      else           mem[acc_line][{acc_word, 6'b0} +: 64] <= acc_wdata[63:0];
    end
  end

  // Read result register, updated only when a read completes
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_read_data <= '0;
    end else if (finish && !acc_we) begin
      ddr_read_data <= acc_burst ? mem[acc_line]
                                 : {448'b0, mem[acc_line][{acc_word, 6'b0} +: 64]};
    end
  end

endmodule

// File: tb/tb_ddr_responder.sv
// tb/tb_ddr_responder.sv - scoreboard testbench for ddr_responder
`timescale 1ns/1ps
module tb_ddr_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
`ifdef DDR_RESP_RANDOM_STALL_EN
  localparam int STALL_MAX = 7;
`else
  localparam int STALL_MAX = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ce = 1'b0;
  logic         we = 1'b0;
  logic         burst = 1'b0;
  logic [63:0]  index = '0;
  logic [511:0] wdata = '0;
  logic [511:0] rdata;
  logic         done;
  logic         ready;

  ddr_responder #(.LINE_AW(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clock              (clock),
    .reset              (reset),
    .ddr_chip_enable    (ce),
    .ddr_index          (index),
    .ddr_write_enable   (we),
    .ddr_burst_mode     (burst),
    .ddr_write_data     (wdata),
    .ddr_read_data      (rdata),
    .ddr_operation_done (done),
    .ddr_ready          (ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           t_min;
    int           t_max;
    int           t_acc;
    logic         is_read;
    logic [511:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   lat_log[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_bits(input string name, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_val(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every done pulse pops one expectation; overdue expectations are reported
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (cyc < mon_e.t_min || cyc > mon_e.t_max) begin
          bad++;
          $display("FAIL done_cycle: got %0d want %0d..%0d", cyc, mon_e.t_min, mon_e.t_max);
        end
        lat_log.push_back(cyc - mon_e.t_acc);
        if (mon_e.is_read) check_bits("read_data", rdata, mon_e.data);
      end
    end else if (sb.size() != 0 && cyc > sb[0].t_max) begin
      total++;
      bad++;
      $display("FAIL missing_done: got none by cycle %0d want by %0d", cyc, sb[0].t_max);
      void'(sb.pop_front());
    end
  end

  task automatic push_exp(input logic w, input logic [511:0] exp_rd);
    exp_t e;
    int   lat;
    lat       = w ? WR_LAT : RD_LAT;
    e.t_acc   = cyc;
    e.t_min   = cyc + lat;
    e.t_max   = cyc + lat + STALL_MAX;
    e.is_read = !w;
    e.data    = exp_rd;
    sb.push_back(e);
  endtask

  task automatic issue(input logic w, input logic b, input logic [63:0] idx,
                       input logic [511:0] wd, input logic [511:0] exp_rd);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: got ready=%b want 1", ready);
      return;
    end
    ce = 1'b1; we = w; burst = b; index = idx; wdata = wd;
    push_exp(w, exp_rd);
    @(negedge clock);
    ce = 1'b0;
    check_val("ready_low_after_accept", longint'(ready), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && n < 60) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (sb.size() != 0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_timeout: got pending=%0d ready=%b want 0 and 1", sb.size(), ready);
    end
  endtask

  initial begin
    logic [511:0] pat, exp5, p6, p7, wtmp;
    logic         sel;
    int           n_acc;
    int           run1[$];

    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i + 1) ^ 8'h03;
    p6 = {8{64'h6666_0000_0000_0006}};
    p7 = {16{32'h7777_0007}};

    // reset values
    repeat (3) begin
      @(negedge clock);
      check_val("reset_ready", longint'(ready), 0);
      check_val("reset_done", longint'(done), 0);
      check_bits("reset_rdata", rdata, '0);
    end
    reset = 1'b0;
    @(negedge clock);
    check_val("ready_after_reset", longint'(ready), 1);
    repeat (10) @(negedge clock);
    check_val("ready_idle", longint'(ready), 1);

    // burst write then burst read of line 5
    issue(1'b1, 1'b1, 64'd40, pat, '0);
    wait_idle();
    issue(1'b0, 1'b1, 64'd40, '0, pat);
    wait_idle();
    repeat (3) @(negedge clock);
    check_bits("read_hold", rdata, pat);

    // word write of index 43 (line 5, word 3); upper payload bits must be ignored
    wtmp = ~pat;
    wtmp[63:0] = 64'hDEAD_BEEF;
    issue(1'b1, 1'b0, 64'd43, wtmp, '0);
    wait_idle();
    check_bits("rdata_unchanged_by_write", rdata, pat);
    exp5 = pat;
    exp5[255:192] = 64'h0000_0000_DEAD_BEEF;
    issue(1'b0, 1'b1, 64'd40, '0, exp5);
    wait_idle();
    issue(1'b0, 1'b0, 64'd43, '0, {448'b0, 64'h0000_0000_DEAD_BEEF});
    wait_idle();
    issue(1'b0, 1'b0, 64'd40, '0, {448'b0, 64'h0b04_0506_0700_0102});
    wait_idle();
    issue(1'b0, 1'b0, 64'h8000_0000_0000_002B, '0, {448'b0, 64'h0000_0000_DEAD_BEEF});
    wait_idle();

    // chip enable held high: one acceptance per LAT+1 cycles, busy strobes dropped
    issue(1'b1, 1'b1, 64'd48, p6, '0);
    wait_idle();
    sel = 1'b1; n_acc = 0;
    ce = 1'b1; we = 1'b0; burst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (ready === 1'b1) begin
        sel   = ~sel;
        index = sel ? 64'd48 : 64'd40;
        push_exp(1'b0, sel ? p6 : exp5);
        n_acc++;
      end else begin
        index = 64'(k * 8 + 3);
      end
      @(negedge clock);
    end
    ce = 1'b0;
    wait_idle();
`ifndef DDR_RESP_RANDOM_STALL_EN
    check_val("hold_accepts", longint'(n_acc), 6);
`endif

    // reset during a busy write to line 7 aborts it
    issue(1'b1, 1'b1, 64'd56, p7, '0);
    wait_idle();
    ce = 1'b1; we = 1'b1; burst = 1'b1; index = 64'd56; wdata = ~p7;
    @(negedge clock);
    ce = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_bits("abort_reset_rdata", rdata, '0);
    reset = 1'b0;
    @(negedge clock);
    check_val("abort_ready", longint'(ready), 1);
    repeat (8) @(negedge clock);
    issue(1'b0, 1'b1, 64'd56, '0, p7);
    wait_idle();

`ifdef DDR_RESP_RANDOM_STALL_EN
    // random stall: 100 reads twice from reset, latency sequence must repeat
    for (int r = 0; r < 2; r++) begin
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      lat_log.delete();
      for (int i = 0; i < 100; i++) issue(1'b0, 1'b1, 64'd40, '0, exp5);
      wait_idle();
      if (r == 0) run1 = lat_log;
    end
    check_val("stall_run_len", longint'(lat_log.size()), longint'(run1.size()));
    for (int i = 0; i < run1.size() && i < lat_log.size(); i++)
      check_val("stall_repeat", longint'(lat_log[i]), longint'(run1[i]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
